// File: rtl/output_drain_scheduler_pkg.sv
// Shared types for the output drain scheduler: FSM state encoding, lane count
// and small helpers used by the top and the credit counter.
package output_drain_scheduler_pkg;

    typedef logic signed [31:0] int32_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DRAIN      = 2'd1,
        WAIT_EMPTY = 2'd2,
        DONE       = 2'd3
    } drain_state_t;

    localparam int DRAIN_LANES = 4;

    // Contiguous valid mask starting at lane 0 for a group of 'lanes' columns.
    function automatic logic [3:0] lane_mask(input logic [2:0] lanes);
        logic [3:0] m;
        for (int i = 0; i < DRAIN_LANES; i++) begin
            m[i] = (3'(i) < lanes);
        end
        return m;
    endfunction

    function automatic logic [2:0] credit_sat(input logic [3:0] sum, input logic [3:0] depth);
        return (sum > depth) ? depth[2:0] : sum[2:0];
    endfunction

endpackage

// File: rtl/output_drain_scheduler_credit.sv
// Free-entry credit counter for the 4-entry output buffer: issue permission,
// same-cycle issue/consume update and saturation on a spurious consume.
module drain_credit_counter
    import output_drain_scheduler_pkg::*;
#(
    parameter int BUF_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_issue,
    input  logic [2:0] i_lanes,
    input  logic       i_consume,
    input  logic       i_wr_pending,
    output logic [2:0] o_credits,
    output logic [2:0] o_credits_next,
    output logic       o_can_issue
);

    localparam logic [2:0] DEPTH3 = 3'(BUF_DEPTH);
    localparam logic [3:0] DEPTH4 = 4'(BUF_DEPTH);

    logic [2:0] r_credits;
    logic [3:0] w_sum;
    logic [2:0] w_next;

    // Four bits so a consume at full credit is visible before saturating.
    always_comb begin
        w_sum = {1'b0, r_credits} + {3'b000, i_consume};
        if (i_issue) begin
            w_sum = w_sum - {1'b0, i_lanes};
        end
        w_next = credit_sat(w_sum, DEPTH4);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_credits <= DEPTH3;
        end else begin
            r_credits <= w_next;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && i_consume && (r_credits == DEPTH3) && !i_wr_pending) begin
            $error("drain_credit_counter: consume with all credits free");
        end
    end
`endif

    assign o_credits      = r_credits;
    assign o_credits_next = w_next;
    assign o_can_issue    = (r_credits >= i_lanes);

endmodule

// File: rtl/output_drain_scheduler.sv
// Drains one rows x cols accumulator tile into the 4-port output buffer in
// raster order, up to 4 columns per cycle, gated by buffer credits.
module output_drain_scheduler
    import output_drain_scheduler_pkg::*;
#(
    parameter int MAX_N     = 16,
    parameter int N_BITS    = $clog2(MAX_N),
    parameter int BUF_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [N_BITS:0]       tile_rows,
    input  logic [N_BITS:0]       tile_cols,
    output logic                  busy,
    output logic                  done,
    output logic                  acc_rd_en,
    output logic [N_BITS-1:0]     acc_rd_row,
    output logic [N_BITS-1:0]     acc_rd_col_base,
    input  logic [4*32-1:0]       acc_rd_data,
    output logic [3:0]            buf_in_valid,
    output logic [4*32-1:0]       buf_in_output,
    output logic [4*N_BITS-1:0]   buf_in_row,
    output logic [4*N_BITS-1:0]   buf_in_col,
    input  logic                  buf_consume
);

    localparam int              NW     = N_BITS + 1;
    localparam logic [NW-1:0]   STEP   = NW'(DRAIN_LANES);
    localparam logic [2:0]      DEPTH3 = 3'(BUF_DEPTH);

    drain_state_t      r_state;
    drain_state_t      w_state_next;
    logic [NW-1:0]     r_rows;
    logic [NW-1:0]     r_cols;
    logic [N_BITS-1:0] r_row;
    logic [N_BITS-1:0] r_col_base;
    logic [3:0]        r_wr_mask;
    logic [N_BITS-1:0] r_wr_row;
    logic [N_BITS-1:0] r_wr_col;

    logic [NW-1:0]     w_remain;
    logic [NW-1:0]     w_col_next;
    logic [2:0]        w_lanes;
    logic              w_row_end;
    logic              w_last_row;
    logic              w_last_group;
    logic              w_issue;
    logic              w_can_issue;
    logic              w_wr_pending;
    logic [2:0]        w_credits;
    logic [2:0]        w_credits_next;

    // Column arithmetic is one bit wider than the index so col_base + 4 at
    // MAX_N does not wrap back to a small value.
    assign w_remain     = r_cols - {1'b0, r_col_base};
    assign w_lanes      = (w_remain >= STEP) ? 3'd4 : w_remain[2:0];
    assign w_col_next   = {1'b0, r_col_base} + STEP;
    assign w_row_end    = (w_col_next >= r_cols);
    assign w_last_row   = (({1'b0, r_row} + NW'(1)) == r_rows);
    assign w_last_group = w_row_end && w_last_row;
    assign w_issue      = (r_state == DRAIN) && w_can_issue;
    assign w_wr_pending = |r_wr_mask;

    drain_credit_counter #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_credit (
        .clk            (clk),
        .reset          (reset),
        .i_issue        (w_issue),
        .i_lanes        (w_lanes),
        .i_consume      (buf_consume),
        .i_wr_pending   (w_wr_pending),
        .o_credits      (w_credits),
        .o_credits_next (w_credits_next),
        .o_can_issue    (w_can_issue)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // WAIT_EMPTY looks at next-cycle credits so the final consume and the
    // exit to DONE land in the same cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if ((tile_rows != '0) && (tile_cols != '0)) begin
                        w_state_next = DRAIN;
                    end else begin
                        w_state_next = DONE;
                    end
                end
            end
            DRAIN: begin
                if (w_issue && w_last_group) begin
                    w_state_next = WAIT_EMPTY;
                end
            end
            WAIT_EMPTY: begin
                if (!w_wr_pending && (w_credits_next == DEPTH3)) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        busy            = (r_state != IDLE);
        done            = (r_state == DONE);
        acc_rd_en       = w_issue;
        acc_rd_row      = r_row;
        acc_rd_col_base = r_col_base;
        buf_in_valid    = r_wr_mask;
        buf_in_output   = acc_rd_data;
        buf_in_row      = '0;
        buf_in_col      = '0;
        for (int i = 0; i < DRAIN_LANES; i++) begin
            if (r_wr_mask[i]) begin
                buf_in_row[i*N_BITS +: N_BITS] = r_wr_row;
                buf_in_col[i*N_BITS +: N_BITS] = r_wr_col + N_BITS'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if ((r_state == IDLE) && start) begin
            r_rows <= tile_rows;
            r_cols <= tile_cols;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_row      <= '0;
            r_col_base <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_row      <= '0;
            r_col_base <= '0;
        end else if (w_issue) begin
            if (w_row_end) begin
                r_col_base <= '0;
                r_row      <= r_row + N_BITS'(1);
            end else begin
                r_col_base <= w_col_next[N_BITS-1:0];
            end
        end
    end

    // Write stage: read data arrives one cycle after issue, so the address
    // and lane mask are delayed by one register to line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_mask <= '0;
        end else begin
            r_wr_mask <= w_issue ? lane_mask(w_lanes) : 4'b0000;
        end
    end

    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_wr_row <= r_row;
            r_wr_col <= r_col_base;
        end
    end

endmodule

// File: tb/tb_output_drain_scheduler.sv
// Directed bench for output_drain_scheduler with a counting sink model of the
// 4-entry output buffer and a positional accumulator data model.
module tb_output_drain_scheduler;

    localparam int MAX_N  = 16;
    localparam int N_BITS = 4;

    logic                clk;
    logic                reset;
    logic                start;
    logic [N_BITS:0]     tile_rows;
    logic [N_BITS:0]     tile_cols;
    logic                busy;
    logic                done;
    logic                acc_rd_en;
    logic [N_BITS-1:0]   acc_rd_row;
    logic [N_BITS-1:0]   acc_rd_col_base;
    logic [4*32-1:0]     acc_rd_data;
    logic [3:0]          buf_in_valid;
    logic [4*32-1:0]     buf_in_output;
    logic [4*N_BITS-1:0] buf_in_row;
    logic [4*N_BITS-1:0] buf_in_col;
    logic                buf_consume;

    output_drain_scheduler #(.MAX_N(MAX_N), .N_BITS(N_BITS), .BUF_DEPTH(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .tile_rows       (tile_rows),
        .tile_cols       (tile_cols),
        .busy            (busy),
        .done            (done),
        .acc_rd_en       (acc_rd_en),
        .acc_rd_row      (acc_rd_row),
        .acc_rd_col_base (acc_rd_col_base),
        .acc_rd_data     (acc_rd_data),
        .buf_in_valid    (buf_in_valid),
        .buf_in_output   (buf_in_output),
        .buf_in_row      (buf_in_row),
        .buf_in_col      (buf_in_col),
        .buf_consume     (buf_consume)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] expval(input int r, input int c);
        return 32'hA500_0000 | 32'(r << 8) | 32'(c);
    endfunction

    logic [N_BITS-1:0] rd_row_q, rd_col_q;
    always @(posedge clk) begin
        rd_row_q <= acc_rd_row;
        rd_col_q <= acc_rd_col_base;
    end
    always_comb begin
        acc_rd_data = '0;
        for (int i = 0; i < 4; i++) begin
            acc_rd_data[i*32 +: 32] = expval(int'(rd_row_q), int'(rd_col_q) + i);
        end
    end

    int   fifo_cnt;
    logic sink_en;
    assign buf_consume = sink_en && (fifo_cnt > 0);
    always @(posedge clk) begin
        if (reset) fifo_cnt <= 0;
        else fifo_cnt <= fifo_cnt + $countones(buf_in_valid) - (buf_consume ? 1 : 0);
    end

    int n_total, n_pass;
    int cyc, start_cyc, done_cyc;
    int n_issue, n_done, n_ovf, n_grp, n_wr, n_rast_err, n_zero_err;
    int exp_r, exp_c, cur_cols, last_r, last_c;
    int iss_col [0:127];
    logic [3:0] grp_mask [0:127];

    initial cyc = 0;
    always @(negedge clk) begin
        int lr, lc;
        logic [31:0] ld;
        cyc++;
        if (!reset) begin
            if (acc_rd_en) begin
                if (n_issue < 128) iss_col[n_issue] = int'(acc_rd_col_base);
                n_issue++;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (fifo_cnt > 4) n_ovf++;
            if (buf_in_valid != 4'b0000) begin
                if (n_grp < 128) grp_mask[n_grp] = buf_in_valid;
                n_grp++;
                for (int i = 0; i < 4; i++) begin
                    lr = int'(buf_in_row[i*N_BITS +: N_BITS]);
                    lc = int'(buf_in_col[i*N_BITS +: N_BITS]);
                    ld = buf_in_output[i*32 +: 32];
                    if (buf_in_valid[i]) begin
                        if (lr != exp_r || lc != exp_c || ld != expval(exp_r, exp_c)) n_rast_err++;
                        last_r = lr;
                        last_c = lc;
                        n_wr++;
                        exp_c++;
                        if (exp_c == cur_cols) begin
                            exp_c = 0;
                            exp_r++;
                        end
                    end else if (lr != 0 || lc != 0) begin
                        n_zero_err++;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        n_issue = 0; n_done = 0; n_ovf = 0; n_grp = 0; n_wr = 0;
        n_rast_err = 0; n_zero_err = 0; exp_r = 0; exp_c = 0;
        last_r = -1; last_c = -1; done_cyc = -1;
    endtask

    task automatic start_tile(input int rows, input int cols);
        cur_cols  = cols;
        clear_stats();
        tile_rows = (N_BITS+1)'(rows);
        tile_cols = (N_BITS+1)'(cols);
        start     = 1'b1;
        start_cyc = cyc + 1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int to);
        to = 1;
        for (int i = 0; i < budget; i++) begin
            if (!busy) begin
                to = 0;
                break;
            end
            tick();
        end
        tick();
    endtask

    typedef struct {
        int rows;
        int cols;
        int exp_issues;
        int exp_writes;
        int exp_last_r;
        int exp_last_c;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int to;
        int bad;
        n_total = 0; n_pass = 0;
        reset = 1'b1; start = 1'b0; sink_en = 1'b1;
        tile_rows = '0; tile_cols = '0; cur_cols = 1;
        clear_stats();

        vecs[0] = '{4,  4,  4,  16,  3,  3};
        vecs[1] = '{2,  6,  4,  12,  1,  5};
        vecs[2] = '{16, 16, 64, 256, 15, 15};
        vecs[3] = '{1,  1,  1,  1,   0,  0};
        vecs[4] = '{5,  7,  10, 35,  4,  6};
        vecs[5] = '{3,  16, 12, 48,  2,  15};
        vecs[6] = '{1,  5,  2,  5,   0,  4};

        repeat (3) tick();
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_rd_en", int'(acc_rd_en), 0);
        check("reset_buf_valid", int'(buf_in_valid), 0);
        reset = 1'b0;
        tick();

        for (int v = 0; v < 7; v++) begin
            start_tile(vecs[v].rows, vecs[v].cols);
            wait_idle(2000, to);
            check("tile_timeout", to, 0);
            check("tile_issues", n_issue, vecs[v].exp_issues);
            check("tile_writes", n_wr, vecs[v].exp_writes);
            check("tile_raster", n_rast_err, 0);
            check("tile_idle_lanes_zero", n_zero_err, 0);
            check("tile_done_count", n_done, 1);
            check("tile_no_overflow", n_ovf, 0);
            check("tile_last_row", last_r, vecs[v].exp_last_r);
            check("tile_last_col", last_c, vecs[v].exp_last_c);
            if (v == 1) begin
                check("2x6_mask0", int'(grp_mask[0]), 4'hF);
                check("2x6_mask1", int'(grp_mask[1]), 4'h3);
                check("2x6_mask2", int'(grp_mask[2]), 4'hF);
                check("2x6_mask3", int'(grp_mask[3]), 4'h3);
            end
            if (v == 2) begin
                bad = 0;
                for (int k = 0; k < 64; k++) if (iss_col[k] != (k % 4) * 4) bad++;
                check("16x16_col_base_seq", bad, 0);
                check("16x16_last_mask", int'(grp_mask[63]), 4'hF);
            end
            if (v == 3) begin
                check("1x1_latency", done_cyc - start_cyc, 4);
            end
        end

        // Zero-sized tiles finish without any reads.
        start_tile(0, 5);
        check("zero_done_next", int'(done), 1);
        check("zero_no_rd", int'(acc_rd_en), 0);
        tick();
        check("zero_idle_after", int'(busy), 0);
        check("zero_issues", n_issue, 0);
        check("zero_done_delay", done_cyc - start_cyc, 1);
        start_tile(3, 0);
        tick();
        check("zero_cols_done", n_done, 1);
        check("zero_cols_issues", n_issue, 0);

        // Stalled sink: one issue uses all credits, then nothing until drained.
        sink_en = 1'b0;
        start_tile(3, 4);
        repeat (10) tick();
        check("stall_issues", n_issue, 1);
        check("stall_rd_en", int'(acc_rd_en), 0);
        check("stall_fifo", fifo_cnt, 4);
        sink_en = 1'b1;
        repeat (3) tick();
        check("stall_still_held", n_issue, 1);
        tick();
        check("resume_issue", int'(acc_rd_en), 1);
        wait_idle(500, to);
        check("stall_timeout", to, 0);
        check("stall_total_issues", n_issue, 3);
        check("stall_writes", n_wr, 12);
        check("stall_raster", n_rast_err, 0);
        check("stall_no_overflow", n_ovf, 0);
        check("stall_done", n_done, 1);

        // Start held high through busy and the done cycle is ignored.
        cur_cols = 4;
        clear_stats();
        tile_rows = 5'd4; tile_cols = 5'd4;
        start = 1'b1;
        to = 1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (done) begin
                to = 0;
                break;
            end
        end
        start = 1'b0;
        check("busy_start_timeout", to, 0);
        repeat (5) tick();
        check("busy_start_done_once", n_done, 1);
        check("busy_start_issues", n_issue, 4);
        check("busy_start_idle", int'(busy), 0);

        // Reset mid-drain aborts, then a fresh tile runs cleanly.
        start_tile(8, 8);
        repeat (12) tick();
        reset = 1'b1;
        tick();
        check("mid_reset_busy", int'(busy), 0);
        check("mid_reset_buf_valid", int'(buf_in_valid), 0);
        check("mid_reset_rd_en", int'(acc_rd_en), 0);
        reset = 1'b0;
        tick();
        sink_en = 1'b0;
        start_tile(8, 8);
        check("post_reset_full_credit_issue", int'(acc_rd_en), 1);
        sink_en = 1'b1;
        wait_idle(2000, to);
        check("post_reset_timeout", to, 0);
        check("post_reset_issues", n_issue, 16);
        check("post_reset_writes", n_wr, 64);
        check("post_reset_raster", n_rast_err, 0);
        check("post_reset_no_overflow", n_ovf, 0);
        check("post_reset_done", n_done, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
